// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a one-entry registered result returned on the owner's response channel.
module alu_arbiter #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic             req0_imm,
  input  logic [2:0]       req0_funct3,
  input  logic [6:0]       req0_funct7,
  input  logic [31:0]      req0_rs1,
  input  logic [31:0]      req0_rs2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_imm,
  input  logic [2:0]       req1_funct3,
  input  logic [6:0]       req1_funct7,
  input  logic [31:0]      req1_rs1,
  input  logic [31:0]      req1_rs2,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             alu_i_en,
  output logic [2:0]       alu_funct3,
  output logic [6:0]       alu_funct7,
  output logic [31:0]      alu_rs1,
  output logic [31:0]      alu_rs2,
  input  logic [31:0]      alu_rd,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag
);

  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic             imm;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [DATA_W-1:0] rs1;
    logic [DATA_W-1:0] rs2;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t req0_s;
  req_t req1_s;
  req_t sel_s;

  logic              out_valid_q, out_valid_d;
  logic              out_owner_q, out_owner_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [TAG_W-1:0]  out_tag_q,   out_tag_d;
  logic              rr_ptr_q,    rr_ptr_d;

  logic can_accept_c;
  logic gnt_any_c;
  logic gnt_idx_c;

  assign req0_s = '{imm: req0_imm, funct3: req0_funct3, funct7: req0_funct7,
                    rs1: req0_rs1, rs2: req0_rs2, tag: req0_tag};
  assign req1_s = '{imm: req1_imm, funct3: req1_funct3, funct7: req1_funct7,
                    rs1: req1_rs1, rs2: req1_rs2, tag: req1_tag};

  // Grant decision; with no grant the index rests on rr_ptr so the ALU mux stays put.
  always_comb begin
    can_accept_c = ~out_valid_q | resp_ready[out_owner_q];
    gnt_any_c    = 1'b0;
    gnt_idx_c    = rr_ptr_q;
    if (!rst && can_accept_c) begin
      unique case (req_valid)
        2'b01:   begin gnt_any_c = 1'b1; gnt_idx_c = 1'b0;     end
        2'b10:   begin gnt_any_c = 1'b1; gnt_idx_c = 1'b1;     end
        2'b11:   begin gnt_any_c = 1'b1; gnt_idx_c = rr_ptr_q; end
        default: begin gnt_any_c = 1'b0; gnt_idx_c = rr_ptr_q; end
      endcase
    end
  end

  assign req_ready = gnt_any_c ? (gnt_idx_c ? 2'b10 : 2'b01) : 2'b00;
  assign sel_s     = gnt_idx_c ? req1_s : req0_s;

  assign alu_i_en   = sel_s.imm;
  assign alu_funct3 = sel_s.funct3;
  assign alu_funct7 = sel_s.funct7;
  assign alu_rs1    = sel_s.rs1;
  assign alu_rs2    = sel_s.rs2;

  // A new accept overwrites the slot only when it is free or draining this edge.
  always_comb begin
    out_valid_d = out_valid_q;
    out_owner_d = out_owner_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    rr_ptr_d    = rr_ptr_q;
    if (gnt_any_c) begin
      out_valid_d = 1'b1;
      out_owner_d = gnt_idx_c;
      out_data_d  = alu_rd;
      out_tag_d   = sel_s.tag;
      rr_ptr_d    = ~gnt_idx_c;
    end else if (out_valid_q && resp_ready[out_owner_q]) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_owner_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      rr_ptr_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_owner_q <= out_owner_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign resp_valid = {out_valid_q & out_owner_q, out_valid_q & ~out_owner_q};
  assign resp_data  = out_data_q;
  assign resp_tag   = out_tag_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_alu_arbiter;

  localparam int unsigned TAG_W = 4;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic             r_imm [2];
  logic [2:0]       r_f3  [2];
  logic [6:0]       r_f7  [2];
  logic [31:0]      r_rs1 [2];
  logic [31:0]      r_rs2 [2];
  logic [TAG_W-1:0] r_tag [2];
  logic             alu_i_en;
  logic [2:0]       alu_funct3;
  logic [6:0]       alu_funct7;
  logic [31:0]      alu_rs1;
  logic [31:0]      alu_rs2;
  logic [31:0]      alu_rd;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;

  int checks   = 0;
  int failures = 0;

  alu_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_imm(r_imm[0]), .req0_funct3(r_f3[0]), .req0_funct7(r_f7[0]),
    .req0_rs1(r_rs1[0]), .req0_rs2(r_rs2[0]), .req0_tag(r_tag[0]),
    .req1_imm(r_imm[1]), .req1_funct3(r_f3[1]), .req1_funct7(r_f7[1]),
    .req1_rs1(r_rs1[1]), .req1_rs2(r_rs2[1]), .req1_tag(r_tag[1]),
    .alu_i_en(alu_i_en), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rd(alu_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag)
  );

  // RV32I integer ALU standing in for the external instance.
  function automatic logic [31:0] alu_fn(input logic imm, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic [31:0] a,
                                         input logic [31:0] b);
    logic arith;
    arith = imm ? b[10] : f7[5];
    case (f3)
      3'd0:    return (!imm && f7[5]) ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return arith ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  assign alu_rd = alu_fn(alu_i_en, alu_funct3, alu_funct7, alu_rs1, alu_rs2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: one result slot plus the requester whose turn it is.
  logic        m_valid = 1'b0;
  logic        m_owner = 1'b0;
  logic [31:0] m_data  = 32'd0;
  logic [3:0]  m_tag   = 4'd0;
  logic        m_rr    = 1'b0;

  initial begin
    @(posedge clk);
    forever begin
      bit   slot_free, gnt;
      logic who;
      logic [1:0] exp_rdy, exp_vld;
      @(negedge clk);
      slot_free = !m_valid || resp_ready[m_owner];
      gnt = 1'b0;
      who = m_rr;
      if (!rst && slot_free && req_valid != 2'b00) begin
        gnt = 1'b1;
        if (req_valid == 2'b01)      who = 1'b0;
        else if (req_valid == 2'b10) who = 1'b1;
      end
      exp_rdy = gnt ? (who ? 2'b10 : 2'b01) : 2'b00;
      exp_vld = m_valid ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      chk("m_req_ready",  32'(req_ready),  32'(exp_rdy));
      chk("m_resp_valid", 32'(resp_valid), 32'(exp_vld));
      chk("m_resp_data",  resp_data, m_data);
      chk("m_resp_tag",   32'(resp_tag),   32'(m_tag));
      if (gnt) begin
        chk("m_alu_i_en", 32'(alu_i_en),   32'(r_imm[who]));
        chk("m_alu_f3",   32'(alu_funct3), 32'(r_f3[who]));
        chk("m_alu_f7",   32'(alu_funct7), 32'(r_f7[who]));
        chk("m_alu_rs1",  alu_rs1, r_rs1[who]);
        chk("m_alu_rs2",  alu_rs2, r_rs2[who]);
      end
      if (rst) begin
        m_valid = 1'b0; m_owner = 1'b0; m_data = 32'd0; m_tag = 4'd0; m_rr = 1'b0;
      end else if (gnt) begin
        m_valid = 1'b1;
        m_owner = who;
        m_data  = alu_fn(r_imm[who], r_f3[who], r_f7[who], r_rs1[who], r_rs2[who]);
        m_tag   = r_tag[who];
        m_rr    = ~who;
      end else if (m_valid && resp_ready[m_owner]) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic set_req(input int i, input logic imm, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag);
    r_imm[i] = imm; r_f3[i] = f3; r_f7[i] = f7;
    r_rs1[i] = a;   r_rs2[i] = b; r_tag[i] = tag;
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; resp_ready = 2'b11;
    set_req(0, 1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 4'd0);

    // Reset held two cycles, then idle.
    step(); step();
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_req_ready",  32'(req_ready),  32'd0);
    chk("rst_resp_data",  resp_data, 32'd0);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("idle_resp_valid", 32'(resp_valid), 32'd0);
    chk("idle_req_ready",  32'(req_ready),  32'd0);

    // Single add from requester 0.
    step();
    set_req(0, 1'b0, 3'd0, 7'd0, 32'd5, 32'd7, 4'd3);
    req_valid = 2'b01;
    @(negedge clk);
    chk("add_req_ready", 32'(req_ready), 32'h1);
    step(); req_valid = 2'b00;
    @(negedge clk);
    chk("add_resp_valid", 32'(resp_valid), 32'h1);
    chk("add_resp_data",  resp_data, 32'd12);
    chk("add_resp_tag",   32'(resp_tag), 32'd3);

    // Lone requester-1 op hands priority back to requester 0.
    step();
    set_req(1, 1'b1, 3'd0, 7'd0, 32'd1, 32'hFFFF_FFFF, 4'd9);
    req_valid = 2'b10;
    @(negedge clk);
    chk("pre_req_ready", 32'(req_ready), 32'h2);

    // Contention: sub 10-3 versus addi 1+(-1).
    step();
    set_req(0, 1'b0, 3'd0, 7'h20, 32'd10, 32'd3, 4'd1);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cont_grant", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      if (i > 0) begin
        chk("cont_resp_valid", 32'(resp_valid), (i % 2 == 1) ? 32'h1 : 32'h2);
        chk("cont_resp_data",  resp_data, (i % 2 == 1) ? 32'd7 : 32'd0);
      end
      step();
    end
    req_valid = 2'b00;
    @(negedge clk);
    chk("cont_last_valid", 32'(resp_valid), 32'h2);
    chk("cont_last_data",  resp_data, 32'd0);

    // Backpressure on requester 1's xori result while requester 0 waits.
    step();
    set_req(1, 1'b1, 3'd4, 7'd0, 32'hF0, 32'hFF, 4'd5);
    req_valid = 2'b10;
    step();
    set_req(0, 1'b0, 3'd0, 7'd0, 32'd5, 32'd7, 4'd2);
    req_valid = 2'b01; resp_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_req_ready",  32'(req_ready),  32'd0);
      chk("bp_resp_valid", 32'(resp_valid), 32'h2);
      chk("bp_resp_data",  resp_data, 32'h0F);
      step();
    end
    resp_ready = 2'b11;
    @(negedge clk);
    chk("bp_release_ready", 32'(req_ready), 32'h1);
    step(); req_valid = 2'b00;
    @(negedge clk);
    chk("bp_after_data", resp_data, 32'd12);

    // Immediate arithmetic shift from requester 1, register form from requester 0.
    step();
    set_req(1, 1'b1, 3'd5, 7'd0, 32'h8000_0000, 32'h404, 4'd6);
    req_valid = 2'b10;
    @(negedge clk);
    chk("srai_i_en", 32'(alu_i_en), 32'd1);
    step();
    set_req(0, 1'b0, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 4'd7);
    req_valid = 2'b01;
    @(negedge clk);
    chk("srai_data", resp_data, 32'hF800_0000);
    chk("sra_i_en",  32'(alu_i_en), 32'd0);
    step(); req_valid = 2'b00;
    @(negedge clk);
    chk("sra_data", resp_data, 32'hF800_0000);

    // Reset while a result is pending and priority sits with requester 1.
    step();
    set_req(0, 1'b0, 3'd0, 7'd0, 32'd1, 32'd2, 4'd4);
    req_valid = 2'b01; resp_ready = 2'b00;
    step(); req_valid = 2'b00;
    @(negedge clk);
    chk("rstmid_pending", 32'(resp_valid), 32'h1);
    step(); rst = 1'b1;
    @(negedge clk);
    chk("rstmid_req_ready", 32'(req_ready), 32'd0);
    step(); rst = 1'b0; req_valid = 2'b11; resp_ready = 2'b11;
    @(negedge clk);
    chk("rstmid_resp_valid", 32'(resp_valid), 32'd0);
    chk("rstmid_grant0",     32'(req_ready),  32'h1);
    step(); req_valid = 2'b00;

    // Randomized traffic checked by the model.
    for (int n = 0; n < 3000; n++) begin
      step();
      rst        = ($urandom_range(0, 99) == 0);
      req_valid  = 2'($urandom_range(0, 3));
      resp_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      for (int i = 0; i < 2; i++) begin
        set_req(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                $urandom_range(0, 1) ? 7'h20 : 7'h00, $urandom, $urandom,
                4'($urandom_range(0, 15)));
      end
    end
    step();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
